inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the immediate decoder: packs an opcode, register and funct fields, and a 64-bit immediate into a 32-bit RV64I instruction word.
- Immediate conventions match the decoder exactly, so an encode-then-decode round trip returns the same immediate. B and J immediates are the halfword offset, with no implicit bit 0.
- Sits between the test-program generator/loader and instruction memory.
- Valid/ready input, 2-entry output FIFO, per-word error flags, saturating error counter.

Parameters:
- DEPTH, 2, output FIFO entries; legal values 2 only (pointer width fixed at 1 bit plus wrap bit).
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- InValid  in  1  request valid
- InReady  out  1  encoder can accept
- Opcode  in  7  instruction opcode
- Rd  in  5  destination register
- Rs1  in  5  source register 1
- Rs2  in  5  source register 2
- Funct3  in  3  funct3
- Funct7  in  7  funct7 (R-type only)
- Imm  in  64  immediate, decoder convention
- OutValid  out  1  FIFO head valid
- OutReady  in  1  consumer accepts head
- Out  out  32  encoded instruction word at head
- ImmErr  out  1  head immediate out of range
- OpErr  out  1  head opcode unsupported
- ErrCnt  out  CNT_W  saturating count of accepted words with ImmErr or OpErr

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO empty, so OutValid=0 and InReady=1.
  - Out=0, ImmErr=0, OpErr=0, ErrCnt=0.
  - Reset mid-transfer discards all stored entries.
- Handshakes:
  - Accept when InValid & InReady; pop when OutValid & OutReady.
  - InReady = !full, registered (no combinational path from OutReady).
  - Latency: accepted on edge N, visible at head from edge N (OutValid=1 in cycle N+1) when the FIFO was empty.
  - Simultaneous push and pop when full: not allowed (InReady=0). When not full, both happen and the count is unchanged.
  - Order is preserved.
  - Out, ImmErr and OpErr stay stable while OutValid & !OutReady.
- Encoding, computed combinationally and stored as {Out, ImmErr, OpErr}:
  - I (0000011, 1100111, 0010011): {Imm[11:0], Rs1, Funct3, Rd, Opcode}.
  - S (0100011): {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode}.
  - B (1100011): Out[31]=Imm[11], Out[7]=Imm[10], Out[30:25]=Imm[9:4], Out[11:8]=Imm[3:0]; rest is Rs2, Rs1, Funct3, Opcode.
  - J (1101111): Out[31]=Imm[19], Out[30:21]=Imm[9:0], Out[20]=Imm[10], Out[19:12]=Imm[18:11], Out[11:7]=Rd, Opcode.
  - R (0110011, 0111011): {Funct7, Rs2, Rs1, Funct3, Rd, Opcode}; Imm ignored, ImmErr=0.
  - Other opcodes: Out=32'h00000013 (nop), OpErr=1, ImmErr=0.
- Range check:
  - I/S/B: ImmErr=1 unless Imm[63:11] are all equal.
  - J: ImmErr=1 unless Imm[63:19] are all equal.
  - On error the truncated encoding is still emitted.
- ErrCnt:
  - Increments on acceptance of a word with ImmErr|OpErr.
  - Saturates at 2^CNT_W-1 and does not wrap.

Optional Feature:
- Macro: INST_ENC_UTYPE_EN.
- Defined: LUI (0110111) and AUIPC (0010111) are encoded as {Imm[19:0], Rd, Opcode}, with ImmErr=1 unless Imm[63:19] are all equal.
- Undefined: both opcodes take the unsupported path (Out=32'h00000013, OpErr=1).

Test Plan:
- Opcode=0010011, Rd=1, Rs1=0, Funct3=0, Imm=64'hFFFF_FFFF_FFFF_FFFF -> Out=32'hFFF00093, ImmErr=0, OpErr=0.
- Opcode=0100011, Funct3=3, Rs1=3, Rs2=2, Imm=8 -> Out=32'h0021B423.
- Opcode=0010011, Imm=2048 -> Out[31:20]=12'h800, ImmErr=1, ErrCnt 0->1. Then Opcode=7'h7F -> Out=32'h00000013, OpErr=1, ErrCnt=2.
- OutReady=0, three back-to-back requests -> first two accepted, InReady=0 from the cycle after the second push, third held. Raise OutReady -> words drain in order, third accepted once a slot frees.
- Random B and J immediates in range -> feeding Out through the immediate decoder returns the original Imm. Out-of-range values -> ImmErr=1.
- Assert rst_n=0 with 2 entries stored -> next cycle OutValid=0, InReady=1, ErrCnt=0. Check LUI Rd=5, Imm=20'h12345 -> Out=32'h123452B7 with the macro defined, OpErr=1 without it.

Source files
------------

// File: rtl/inst_encoder_if.sv
//==============================================================================
// Module      : inst_encoder_if
// Description : Request/response bundle between the program loader and the
//               RV64I instruction encoder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface inst_encoder_if #(
    parameter int CNT_W = 16
);
    logic             InValid;
    logic             InReady;
    logic [6:0]       Opcode;
    logic [4:0]       Rd;
    logic [4:0]       Rs1;
    logic [4:0]       Rs2;
    logic [2:0]       Funct3;
    logic [6:0]       Funct7;
    logic [63:0]      Imm;
    logic             OutValid;
    logic             OutReady;
    logic [31:0]      Out;
    logic             ImmErr;
    logic             OpErr;
    logic [CNT_W-1:0] ErrCnt;

    modport master (
        output InValid, Opcode, Rd, Rs1, Rs2, Funct3, Funct7, Imm, OutReady,
        input  InReady, OutValid, Out, ImmErr, OpErr, ErrCnt
    );

    modport slave (
        input  InValid, Opcode, Rd, Rs1, Rs2, Funct3, Funct7, Imm, OutReady,
        output InReady, OutValid, Out, ImmErr, OpErr, ErrCnt
    );
endinterface

`default_nettype wire

// File: rtl/inst_encoder.sv
//==============================================================================
// Module      : inst_encoder
// Description : Packs RV64I fields plus a decoder-convention immediate into a
//               32-bit instruction word, buffered in a 2-entry output FIFO with
//               per-word error flags and a saturating error counter.
//               Optional macro INST_ENC_UTYPE_EN enables LUI/AUIPC encoding.
//               DEPTH supports the value 2 only.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    inst_encoder_if.slave      bus
);

    localparam int          c_AW       = 1;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [6:0]  c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  c_OP_JALR  = 7'b1100111;
    localparam logic [6:0]  c_OP_IMM   = 7'b0010011;
    localparam logic [6:0]  c_OP_STORE = 7'b0100011;
    localparam logic [6:0]  c_OP_BR    = 7'b1100011;
    localparam logic [6:0]  c_OP_JAL   = 7'b1101111;
    localparam logic [6:0]  c_OP_REG   = 7'b0110011;
    localparam logic [6:0]  c_OP_REG32 = 7'b0111011;
`ifdef INST_ENC_UTYPE_EN
    localparam logic [6:0]  c_OP_LUI   = 7'b0110111;
    localparam logic [6:0]  c_OP_AUIPC = 7'b0010111;
`endif

    // Entry layout: {word[31:0], imm_err, op_err}
    typedef logic [33:0] entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [c_AW:0]    wr_ptr_q, wr_ptr_d;
    logic [c_AW:0]    rd_ptr_q, rd_ptr_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [31:0]      w_word;
    logic             w_imm_err;
    logic             w_op_err;
    logic             w_fit12;
    logic             w_fit20;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    entry_t           w_head;

    // An immediate fits N signed bits when every bit above N-1 matches the sign.
    assign w_fit12 = (&bus.Imm[63:11]) | ~(|bus.Imm[63:11]);
    assign w_fit20 = (&bus.Imm[63:19]) | ~(|bus.Imm[63:19]);

    always_comb begin
        w_word    = c_NOP;
        w_imm_err = 1'b0;
        w_op_err  = 1'b0;
        case (bus.Opcode)
            c_OP_LOAD, c_OP_JALR, c_OP_IMM: begin
                w_word    = {bus.Imm[11:0], bus.Rs1, bus.Funct3, bus.Rd, bus.Opcode};
                w_imm_err = ~w_fit12;
            end
            c_OP_STORE: begin
                w_word    = {bus.Imm[11:5], bus.Rs2, bus.Rs1, bus.Funct3,
                             bus.Imm[4:0], bus.Opcode};
                w_imm_err = ~w_fit12;
            end
            c_OP_BR: begin
                w_word    = {bus.Imm[11], bus.Imm[9:4], bus.Rs2, bus.Rs1, bus.Funct3,
                             bus.Imm[3:0], bus.Imm[10], bus.Opcode};
                w_imm_err = ~w_fit12;
            end
            c_OP_JAL: begin
                w_word    = {bus.Imm[19], bus.Imm[9:0], bus.Imm[10], bus.Imm[18:11],
                             bus.Rd, bus.Opcode};
                w_imm_err = ~w_fit20;
            end
            c_OP_REG, c_OP_REG32: begin
                w_word = {bus.Funct7, bus.Rs2, bus.Rs1, bus.Funct3, bus.Rd, bus.Opcode};
            end
`ifdef INST_ENC_UTYPE_EN
            c_OP_LUI, c_OP_AUIPC: begin
                w_word    = {bus.Imm[19:0], bus.Rd, bus.Opcode};
                w_imm_err = ~w_fit20;
            end
`endif
            default: begin
                w_word   = c_NOP;
                w_op_err = 1'b1;
            end
        endcase
    end

    // Full and empty are told apart by the wrap bit above the 1-bit address.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_push  = bus.InValid & in_ready_q;
    assign w_pop   = ~w_empty & bus.OutReady;
    assign w_head  = mem_q[rd_ptr_q[c_AW-1:0]];

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_cnt_d = err_cnt_q;
        if (w_push) begin
            mem_d[wr_ptr_q[c_AW-1:0]] = {w_word, w_imm_err, w_op_err};
            wr_ptr_d                  = wr_ptr_q + (c_AW+1)'(1);
            if ((w_imm_err | w_op_err) && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + (c_AW+1)'(1);
        end
        in_ready_d = ~((wr_ptr_d[c_AW] != rd_ptr_d[c_AW]) &&
                       (wr_ptr_d[c_AW-1:0] == rd_ptr_d[c_AW-1:0]));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b1;
            err_cnt_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= in_ready_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.InReady  = in_ready_q;
    assign bus.OutValid = ~w_empty;
    assign bus.Out      = w_empty ? 32'h0 : w_head[33:2];
    assign bus.ImmErr   = ~w_empty & w_head[1];
    assign bus.OpErr    = ~w_empty & w_head[0];
    assign bus.ErrCnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
//==============================================================================
// Module      : tb_inst_encoder
// Description : Randomized and directed self-checking bench for inst_encoder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_inst_encoder;

    localparam int CW = 4;

    typedef struct {
        logic [31:0] w;
        bit          ie;
        bit          oe;
        logic [6:0]  op;
        logic [63:0] imm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];
    int   err_m;

    inst_encoder_if #(.CNT_W(CW)) bus ();

    inst_encoder #(.DEPTH(2), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: field placement by plain shifts, range by signed compare.
    function automatic void model(input logic [6:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [63:0] imm,
                                  output logic [31:0] w, output bit ie, output bit oe);
        longint          s;
        longint unsigned m;
        longint unsigned r;
        bit              fit12;
        bit              fit20;
        s     = imm;
        m     = imm;
        fit12 = (s >= -2048) && (s <= 2047);
        fit20 = (s >= -524288) && (s <= 524287);
        ie    = 0;
        oe    = 0;
        r     = 64'h13;
        case (op)
            7'h03, 7'h67, 7'h13: begin
                r  = ((m & 64'hFFF) << 20) | (64'(rs1) << 15) | (64'(f3) << 12)
                   | (64'(rd) << 7) | 64'(op);
                ie = !fit12;
            end
            7'h23: begin
                r  = (((m >> 5) & 64'h7F) << 25) | (64'(rs2) << 20) | (64'(rs1) << 15)
                   | (64'(f3) << 12) | ((m & 64'h1F) << 7) | 64'(op);
                ie = !fit12;
            end
            7'h63: begin
                r  = (((m >> 11) & 1) << 31) | (((m >> 4) & 64'h3F) << 25)
                   | (64'(rs2) << 20) | (64'(rs1) << 15) | (64'(f3) << 12)
                   | ((m & 64'hF) << 8) | (((m >> 10) & 1) << 7) | 64'(op);
                ie = !fit12;
            end
            7'h6F: begin
                r  = (((m >> 19) & 1) << 31) | ((m & 64'h3FF) << 21)
                   | (((m >> 10) & 1) << 20) | (((m >> 11) & 64'hFF) << 12)
                   | (64'(rd) << 7) | 64'(op);
                ie = !fit20;
            end
            7'h33, 7'h3B: begin
                r = (64'(f7) << 25) | (64'(rs2) << 20) | (64'(rs1) << 15)
                  | (64'(f3) << 12) | (64'(rd) << 7) | 64'(op);
            end
`ifdef INST_ENC_UTYPE_EN
            7'h37, 7'h17: begin
                r  = ((m & 64'hFFFFF) << 12) | (64'(rd) << 7) | 64'(op);
                ie = !fit20;
            end
`endif
            default: begin
                r  = 64'h13;
                oe = 1;
            end
        endcase
        w = r[31:0];
    endfunction

    function automatic longint dec_b(input logic [31:0] w);
        longint unsigned x;
        longint          v;
        x = w;
        v = longint'((((x >> 31) & 1) << 11) | (((x >> 7) & 1) << 10)
                     | (((x >> 25) & 64'h3F) << 4) | ((x >> 8) & 64'hF));
        if (v >= 2048) v = v - 4096;
        return v;
    endfunction

    function automatic longint dec_j(input logic [31:0] w);
        longint unsigned x;
        longint          v;
        x = w;
        v = longint'((((x >> 31) & 1) << 19) | (((x >> 12) & 64'hFF) << 11)
                     | (((x >> 20) & 1) << 10) | ((x >> 21) & 64'h3FF));
        if (v >= 524288) v = v - 1048576;
        return v;
    endfunction

    // Called at a falling edge with this cycle's inputs already driven.
    task automatic step(output bit acc);
        exp_t e;
        check("in_ready", 64'(bus.InReady), 64'(sb.size() < 2));
        check("out_valid", 64'(bus.OutValid), 64'(sb.size() > 0));
        check("err_cnt", 64'(bus.ErrCnt), 64'(err_m));
        if (sb.size() > 0) begin
            check("out_word", 64'(bus.Out), 64'(sb[0].w));
            check("imm_err", 64'(bus.ImmErr), 64'(sb[0].ie));
            check("op_err", 64'(bus.OpErr), 64'(sb[0].oe));
        end
        acc = 0;
        if (!rst_n) begin
            sb.delete();
            err_m = 0;
        end else begin
            if (bus.OutValid && bus.OutReady && sb.size() > 0) begin
                if (!sb[0].ie && sb[0].op == 7'h63)
                    check("roundtrip_b", 64'(dec_b(bus.Out)), sb[0].imm);
                if (!sb[0].ie && sb[0].op == 7'h6F)
                    check("roundtrip_j", 64'(dec_j(bus.Out)), sb[0].imm);
                void'(sb.pop_front());
            end
            if (bus.InValid && bus.InReady) begin
                model(bus.Opcode, bus.Rd, bus.Rs1, bus.Rs2, bus.Funct3, bus.Funct7,
                      bus.Imm, e.w, e.ie, e.oe);
                e.op  = bus.Opcode;
                e.imm = bus.Imm;
                sb.push_back(e);
                if ((e.ie || e.oe) && err_m < (1 << CW) - 1) err_m++;
                acc = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [63:0] imm);
        bus.Opcode = op;
        bus.Rd     = rd;
        bus.Rs1    = rs1;
        bus.Rs2    = rs2;
        bus.Funct3 = f3;
        bus.Funct7 = f7;
        bus.Imm    = imm;
    endtask

    task automatic directed(input string tag, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [63:0] imm,
                            input logic [31:0] exp_w, input bit exp_ie, input bit exp_oe);
        bit acc;
        acc = 0;
        set_req(op, rd, rs1, rs2, f3, 7'h0, imm);
        bus.InValid  = 1;
        bus.OutReady = 0;
        for (int i = 0; i < 10 && !acc; i++) step(acc);
        check({tag, "_accept"}, 64'(acc), 64'd1);
        bus.InValid = 0;
        step(acc);
        check({tag, "_word"}, 64'(bus.Out), 64'(exp_w));
        check({tag, "_ie"}, 64'(bus.ImmErr), 64'(exp_ie));
        check({tag, "_oe"}, 64'(bus.OpErr), 64'(exp_oe));
        bus.OutReady = 1;
        step(acc);
        bus.OutReady = 0;
    endtask

    function automatic logic [63:0] rand_imm();
        longint bnd [8];
        longint t;
        bnd = '{2047, 2048, -2048, -2049, 524287, 524288, -524288, -524289};
        case ($urandom_range(0, 3))
            0:       t = longint'($urandom_range(0, 4095)) - 2048;
            1:       t = longint'($urandom_range(0, 1048575)) - 524288;
            2:       t = bnd[$urandom_range(0, 7)];
            default: t = longint'({$urandom, $urandom});
        endcase
        return t;
    endfunction

    initial begin
        logic [6:0] ops [13];
        bit         acc;
        bit         pending;
        ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h3B,
                7'h37, 7'h17, 7'h7F, 7'h00, 7'h0F};
        n_cmp = 0;
        n_err = 0;
        err_m = 0;
        rst_n = 0;
        bus.InValid  = 0;
        bus.OutReady = 0;
        set_req(7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out", 64'(bus.Out), 64'h0);
        step(acc);
        rst_n = 1;

        directed("addi_m1", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                 32'hFFF00093, 0, 0);
        directed("sd", 7'h23, 5'd0, 5'd3, 5'd2, 3'd3, 64'd8, 32'h0021B423, 0, 0);
        directed("imm2048", 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 64'd2048, 32'h80000013, 1, 0);
        check("errcnt_one", 64'(bus.ErrCnt), 64'd1);
        directed("bad_op", 7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 64'd0, 32'h00000013, 0, 1);
        check("errcnt_two", 64'(bus.ErrCnt), 64'd2);
`ifdef INST_ENC_UTYPE_EN
        directed("lui", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345, 32'h123452B7, 0, 0);
`else
        directed("lui", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345, 32'h00000013, 0, 1);
`endif

        // Back-pressure: two fill the FIFO, the third waits for a free slot.
        bus.OutReady = 0;
        bus.InValid  = 1;
        set_req(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'h0, 64'd1);
        step(acc);
        check("bp_acc0", 64'(acc), 64'd1);
        set_req(7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'h0, 64'd2);
        step(acc);
        check("bp_acc1", 64'(acc), 64'd1);
        check("bp_full_ready", 64'(bus.InReady), 64'd0);
        set_req(7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 7'h0, 64'd3);
        step(acc);
        check("bp_held", 64'(acc), 64'd0);
        bus.OutReady = 1;
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) step(acc);
        check("bp_acc2", 64'(acc), 64'd1);
        bus.InValid = 0;
        repeat (4) step(acc);

        // Reset with two entries stored.
        bus.OutReady = 0;
        bus.InValid  = 1;
        set_req(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 64'd0);
        step(acc);
        step(acc);
        bus.InValid = 0;
        rst_n = 0;
        step(acc);
        rst_n = 1;
        check("mid_rst_valid", 64'(bus.OutValid), 64'd0);
        check("mid_rst_ready", 64'(bus.InReady), 64'd1);
        check("mid_rst_errcnt", 64'(bus.ErrCnt), 64'd0);

        pending = 0;
        for (int c = 0; c < 500; c++) begin
            if (!pending && $urandom_range(0, 9) < 7) begin
                set_req(ops[$urandom_range(0, 12)], 5'($urandom), 5'($urandom),
                        5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
                pending = 1;
            end
            bus.InValid  = pending;
            bus.OutReady = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc) pending = 0;
        end
        bus.InValid  = 0;
        bus.OutReady = 1;
        repeat (4) step(acc);

        // Saturation of the error counter.
        rst_n = 0;
        step(acc);
        rst_n = 1;
        bus.InValid = 1;
        set_req(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 64'd0);
        repeat (20) step(acc);
        bus.InValid = 0;
        repeat (3) step(acc);
        check("errcnt_sat", 64'(bus.ErrCnt), 64'((1 << CW) - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
